imem_sram_arbiter: RTL and testbench
====================================

Name: imem_sram_arbiter

Overview:
Shares one single-port instruction SRAM between three requesters: the external line loader (iMem write path, 240-bit lines at 8-bit line addresses) and two fetch read ports.
- Each line holds 5 x 48-bit instructions.
- Sits between top_with_mem's fetch/load logic and the SRAM macro.
- Arbitrates one access per cycle, tracks in-flight reads and returns tagged read data to the correct fetch port.

Parameters:
ADDR_W, 8, line address width
LINE_W, 240, SRAM line width (5 x 48-bit instructions)
SRAM_RD_LAT, 1, SRAM cycles from ce to valid rdata (1..3)
MAX_WR_BURST, 4, consecutive write grants allowed while any read is pending

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
wr_req  in  1  loader write request (iMem_WEPin)
wr_addr  in  ADDR_W  loader line address (WEAddress)
wr_data  in  LINE_W  loader line data (idataWrite)
wr_gnt  out  1  write accepted this cycle
rd1_req  in  1  fetch port 1 read request
rd1_addr  in  ADDR_W  fetch port 1 line address
rd1_gnt  out  1  port 1 read accepted this cycle
rd1_valid  out  1  port 1 read data valid (1-cycle pulse)
rd1_data  out  LINE_W  port 1 read line
rd2_req, rd2_addr, rd2_gnt, rd2_valid, rd2_data: same as port 1, for fetch port 2
sram_ce  out  1  SRAM access enable
sram_we  out  1  SRAM write enable (valid only with ce)
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  LINE_W  SRAM write data
sram_rdata  in  LINE_W  SRAM read data, SRAM_RD_LAT after ce

Behaviour:
- Grants are combinational from the current-cycle req inputs and registered arbiter state. At most one of wr_gnt, rd1_gnt, rd2_gnt is high per cycle.
- The granted request drives sram_ce=1, sram_we (1 for write only), sram_addr and sram_wdata in the same cycle. With no grant: sram_ce=0, sram_we=0.
- Requesters hold req/addr/data stable until they see gnt. A request accepted in cycle T is not re-evaluated in T+1 unless req is still high; a still-high req is treated as a new request.
- Priority: write over reads, except when the burst limiter fires.
- Burst limiter:
  - wr_burst_cnt increments on each wr_gnt while (rd1_req|rd2_req), saturating at MAX_WR_BURST.
  - It clears on any read grant, or on any cycle with no read pending.
  - When wr_burst_cnt==MAX_WR_BURST and a read is pending, one read is granted instead of the write. wr_gnt=0 that cycle and the counter clears.
- Read-vs-read arbitration: 2-way round robin, pointer reset to port 1. After a read grant, the pointer moves to the other port. Only one port requesting: it wins regardless of the pointer.
- Return pipeline: a shift register SRAM_RD_LAT deep carries a {valid, port_id} tag per granted read.
  - When the tag exits, sram_rdata is captured into rdN_data, and rdN_valid pulses in the next cycle.
  - Total latency: gnt in cycle T -> rdN_valid high in cycle T+SRAM_RD_LAT+1.
  - Reads to the same port return in grant order. Back-to-back reads are fully pipelined, one per cycle.
- rdN_data holds its last value between valid pulses.
- Read-after-write to the same address in a later cycle returns the new data; SRAM order guarantees this, and the block adds no forwarding.
- Reset:
  - All gnt, valid, sram_ce and sram_we are 0; rd1_data and rd2_data are 0.
  - RR pointer goes to port 1, wr_burst_cnt to 0, and all tags are cleared.
  - Reads in flight at reset are dropped; no valid pulse appears after reset.
  - req inputs are ignored during reset cycles.
- Address wrap: addresses are used unmodified, and 8'hFF is a legal line.

Decomposition:
- Package imem_arb_pkg holds:
  - ADDR_W, LINE_W, INSTR_W=48, INSTR_PER_LINE=5.
  - The port_id typedef: PORT_RD1=1'b0, PORT_RD2=1'b1.
  - The rd_tag_t struct {valid, port_id}.
- One sub-module, rr_arb2: 2-requester round-robin with registered pointer, advance input and one-hot grant output.

Test Plan:
- Reset then rd1_req addr 8'h03, SRAM_RD_LAT=1 -> rd1_gnt in cycle T, sram_ce=1/we=0/addr=03 in T, rd1_valid pulse in T+2 with preloaded line 3; rd2_valid stays 0.
- wr_req addr 8'h10 data 240'hA5..A5, then rd2_req addr 8'h10 the next cycle -> wr_gnt, then rd2_gnt, and rd2_data=240'hA5..A5.
- rd1_req and rd2_req held high 6 cycles -> grants alternate 1,2,1,2,1,2; six valid pulses in matching order, each carrying its port's line.
- wr_req held high 10 cycles plus rd1_req high, MAX_WR_BURST=4 -> wr_gnt x4, rd1_gnt x1, wr_gnt resumes; rd1 is never starved beyond 4 write cycles.
- rd1 and rd2 grants in consecutive cycles, then reset asserted the next cycle -> no rd1_valid or rd2_valid after reset; all outputs 0; first post-reset dual request grants port 1.
- SRAM_RD_LAT=3, read addr 8'hFF -> rd1_valid at T+4 with line 255 data.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared widths, port identifiers and the return-tag record for the iMem SRAM arbiter.
// Pure declarations: no latency and no flow control of its own.
package imem_arb_pkg;

    localparam int ADDR_W         = 8;
    localparam int INSTR_W        = 48;
    localparam int INSTR_PER_LINE = 5;
    localparam int LINE_W         = INSTR_W * INSTR_PER_LINE;

    typedef enum logic {
        PORT_RD1 = 1'b0,
        PORT_RD2 = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port_id;
    } rd_tag_t;

endpackage

// File: rtl/imem_sram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves past the winner on advance.
// Grant is combinational (0 cycles); the caller masks it and pulses advance when it is used.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    import imem_arb_pkg::*;

    port_id_t ptr_q;

    // The pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ptr_q == PORT_RD1) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= PORT_RD1;
        end else if (advance && gnt[0]) begin
            ptr_q <= PORT_RD2;
        end else if (advance && gnt[1]) begin
            ptr_q <= PORT_RD1;
        end
    end

endmodule

// File: rtl/imem_sram_arbiter.sv
// Shares one single-port instruction SRAM between the line loader and two fetch read ports.
// Grant same cycle, read data SRAM_RD_LAT+1 cycles after grant; requesters hold req until gnt.
module imem_sram_arbiter #(
    parameter int ADDR_W       = imem_arb_pkg::ADDR_W,
    parameter int LINE_W       = imem_arb_pkg::LINE_W,
    parameter int SRAM_RD_LAT  = 1,
    parameter int MAX_WR_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LINE_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_gnt,
    output logic              rd1_valid,
    output logic [LINE_W-1:0] rd1_data,
    input  logic              rd2_req,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd2_gnt,
    output logic              rd2_valid,
    output logic [LINE_W-1:0] rd2_data,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LINE_W-1:0] sram_wdata,
    input  logic [LINE_W-1:0] sram_rdata
);
    import imem_arb_pkg::*;

    localparam int CNT_W = $clog2(MAX_WR_BURST + 1);

    logic [CNT_W-1:0] wr_burst_cnt;
    logic             rd_pend;
    logic             burst_hit;
    logic             rd_slot;
    logic             rd_any;
    logic [1:0]       arb_gnt;
    port_id_t         rd_port;
    rd_tag_t          tag_q [SRAM_RD_LAT];
    rd_tag_t          exit_tag;

    assign rd_pend   = rd1_req | rd2_req;
    assign burst_hit = rd_pend && (wr_burst_cnt == CNT_W'(MAX_WR_BURST));

    // Writes win unless the loader has starved a pending read for a full burst.
    assign wr_gnt  = !reset && wr_req && !burst_hit;
    assign rd_slot = !reset && rd_pend && (!wr_req || burst_hit);

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .reset   (reset),
        .req     ({rd2_req, rd1_req}),
        .advance (rd_slot),
        .gnt     (arb_gnt)
    );

    assign rd1_gnt = rd_slot && arb_gnt[0];
    assign rd2_gnt = rd_slot && arb_gnt[1];
    assign rd_any  = rd1_gnt | rd2_gnt;
    assign rd_port = rd2_gnt ? PORT_RD2 : PORT_RD1;

    always_comb begin
        sram_ce    = wr_gnt | rd_any;
        sram_we    = wr_gnt;
        sram_addr  = '0;
        sram_wdata = '0;
        if (wr_gnt) begin
            sram_addr  = wr_addr;
            sram_wdata = wr_data;
        end else if (rd1_gnt) begin
            sram_addr = rd1_addr;
        end else if (rd2_gnt) begin
            sram_addr = rd2_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_burst_cnt <= '0;
        end else if (rd_any || !rd_pend) begin
            wr_burst_cnt <= '0;
        end else if (wr_gnt && (wr_burst_cnt != CNT_W'(MAX_WR_BURST))) begin
            wr_burst_cnt <= wr_burst_cnt + CNT_W'(1);
        end
    end

    // The tag rides alongside the SRAM access so it exits exactly when rdata is valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SRAM_RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= rd_tag_t'{valid: rd_any, port_id: rd_port};
            for (int i = 1; i < SRAM_RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign exit_tag = tag_q[SRAM_RD_LAT-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd1_valid <= 1'b0;
            rd2_valid <= 1'b0;
            rd1_data  <= '0;
            rd2_data  <= '0;
        end else begin
            rd1_valid <= exit_tag.valid && (exit_tag.port_id == PORT_RD1);
            rd2_valid <= exit_tag.valid && (exit_tag.port_id == PORT_RD2);
            if (exit_tag.valid && (exit_tag.port_id == PORT_RD1)) begin
                rd1_data <= sram_rdata;
            end
            if (exit_tag.valid && (exit_tag.port_id == PORT_RD2)) begin
                rd2_data <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_sram_arbiter.sv
// Bench for imem_sram_arbiter: grant table, read-return scoreboard, reset and latency-3 sequences.
module tb_imem_sram_arbiter;
    localparam int AW = 8;
    localparam int LW = 240;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          wr_req, wr_gnt, rd1_req, rd1_gnt, rd1_valid, rd2_req, rd2_gnt, rd2_valid;
    logic [AW-1:0] wr_addr, rd1_addr, rd2_addr, sram_addr;
    logic [LW-1:0] wr_data, rd1_data, rd2_data, sram_wdata, sram_rdata;
    logic          sram_ce, sram_we;

    logic          wr_req3, wr_gnt3, rd1_req3, rd1_gnt3, rd1_valid3, rd2_req3, rd2_gnt3, rd2_valid3;
    logic [AW-1:0] wr_addr3, rd1_addr3, rd2_addr3, sram_addr3;
    logic [LW-1:0] wr_data3, rd1_data3, rd2_data3, sram_wdata3, sram_rdata3;
    logic          sram_ce3, sram_we3;

    imem_sram_arbiter #(.ADDR_W(AW), .LINE_W(LW), .SRAM_RD_LAT(1), .MAX_WR_BURST(4)) u_dut (
        .clock(clock), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .rd2_req(rd2_req), .rd2_addr(rd2_addr), .rd2_gnt(rd2_gnt), .rd2_valid(rd2_valid), .rd2_data(rd2_data),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    imem_sram_arbiter #(.ADDR_W(AW), .LINE_W(LW), .SRAM_RD_LAT(3), .MAX_WR_BURST(4)) u_dut3 (
        .clock(clock), .reset(reset),
        .wr_req(wr_req3), .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_gnt(wr_gnt3),
        .rd1_req(rd1_req3), .rd1_addr(rd1_addr3), .rd1_gnt(rd1_gnt3), .rd1_valid(rd1_valid3), .rd1_data(rd1_data3),
        .rd2_req(rd2_req3), .rd2_addr(rd2_addr3), .rd2_gnt(rd2_gnt3), .rd2_valid(rd2_valid3), .rd2_data(rd2_data3),
        .sram_ce(sram_ce3), .sram_we(sram_we3), .sram_addr(sram_addr3), .sram_wdata(sram_wdata3),
        .sram_rdata(sram_rdata3)
    );

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 8; i++) l[i*8 +: 8] = a + 8'(i);
        return l;
    endfunction

    // SRAM model, latency 1, preloaded with line_of(address).
    logic [LW-1:0] mem [256];
    logic          init_done = 1'b0;
    logic [LW-1:0] rpipe = '0;
    always @(posedge clock) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= line_of(8'(i));
            init_done <= 1'b1;
        end else if (sram_ce && sram_we) begin
            mem[sram_addr] <= sram_wdata;
        end
        if (sram_ce && !sram_we) rpipe <= mem[sram_addr];
    end
    assign sram_rdata = rpipe;

    // Read-only SRAM model, latency 3.
    logic [LW-1:0] p3 [3];
    always @(posedge clock) begin
        p3[0] <= line_of(sram_addr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign sram_rdata3 = p3[2];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected read returns, pushed on grant, popped on valid.
    typedef struct {
        logic          port;
        logic [LW-1:0] data;
        int            due;
    } exp_t;
    exp_t          sb[$];
    logic [LW-1:0] ref_mem [256];

    task automatic sb_pop(input logic port, input logic [LW-1:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: port%0d got valid expected none at cycle %0d", port + 1, cyc);
        end else begin
            e = sb.pop_front();
            chk1("sb_port", port, e.port);
            chkw("sb_data", data, e.data);
            chki("sb_cycle", cyc, e.due);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = line_of(8'(i));
        forever begin
            @(negedge clock);
            if (wr_req | rd1_req | rd2_req | wr_gnt | rd1_gnt | rd2_gnt) begin
                chk1("onehot_gnt", $countones({wr_gnt, rd1_gnt, rd2_gnt}) <= 1, 1'b1);
                chk1("sram_ce", sram_ce, wr_gnt | rd1_gnt | rd2_gnt);
                chk1("sram_we", sram_we, wr_gnt);
            end
            if (wr_gnt) begin
                chki("sram_addr_wr", int'(sram_addr), int'(wr_addr));
                chkw("sram_wdata", sram_wdata, wr_data);
                ref_mem[wr_addr] = wr_data;
            end
            if (rd1_gnt) begin
                chki("sram_addr_rd1", int'(sram_addr), int'(rd1_addr));
                sb.push_back('{1'b0, ref_mem[rd1_addr], cyc + 2});
            end
            if (rd2_gnt) begin
                chki("sram_addr_rd2", int'(sram_addr), int'(rd2_addr));
                sb.push_back('{1'b1, ref_mem[rd2_addr], cyc + 2});
            end
            if (rd1_valid) sb_pop(1'b0, rd1_data);
            if (rd2_valid) sb_pop(1'b1, rd2_data);
            if (reset) sb.delete();
        end
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [7:0]    wb;
        logic          r1;
        logic [AW-1:0] a1;
        logic          r2;
        logic [AW-1:0] a2;
        logic [2:0]    exp;
        logic          c1;
        logic [LW-1:0] e1;
        logic          c2;
        logic [LW-1:0] e2;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic wr, input logic [AW-1:0] wa, input logic [7:0] wb,
                       input logic r1, input logic [AW-1:0] a1,
                       input logic r2, input logic [AW-1:0] a2, input logic [2:0] exp);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wb = wb; v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2;
        v.exp = exp; v.c1 = 1'b0; v.e1 = '0; v.c2 = 1'b0; v.e2 = '0;
        vecs.push_back(v);
    endtask

    task automatic idle_in();
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd1_req = 1'b0; rd1_addr = '0; rd2_req = 1'b0; rd2_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_gnt(input string name, input logic [2:0] exp);
        chki(name, int'({wr_gnt, rd1_gnt, rd2_gnt}), int'(exp));
    endtask

    task automatic chk_quiet(input string name);
        chk_gnt({name, "_gnt"}, 3'b000);
        chk1({name, "_ce"}, sram_ce, 1'b0);
        chk1({name, "_we"}, sram_we, 1'b0);
        chk1({name, "_v1"}, rd1_valid, 1'b0);
        chk1({name, "_v2"}, rd2_valid, 1'b0);
        chkw({name, "_d1"}, rd1_data, '0);
        chkw({name, "_d2"}, rd2_data, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int            t0;
    int            pulses;
    int            arrival;
    logic [LW-1:0] got3;
    logic [7:0]    a5;

    initial begin
        a5 = 8'hA5;
        // Single read, then write followed by a read of the same line.
        add(0, 0, 0, 1, 8'h03, 0, 0, 3'b010);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);
        vecs[vecs.size()-1].c1 = 1'b1;
        vecs[vecs.size()-1].e1 = line_of(8'h03);
        add(1, 8'h10, 8'hA5, 0, 0, 0, 0, 3'b100);
        add(0, 0, 0, 0, 0, 1, 8'h10, 3'b001);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);
        vecs[vecs.size()-1].c2 = 1'b1;
        vecs[vecs.size()-1].e2 = {30{a5}};
        // Both fetch ports held: grants alternate starting with port 1.
        for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 8'h20, 1, 8'h21, (i % 2 == 0) ? 3'b010 : 3'b001);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);
        // Loader vs pending rd1: four writes, then the read, then writes resume.
        for (int i = 0; i < 4; i++) add(1, 8'(8'h40 + i), 8'(8'h60 + i), 1, 8'h40, 0, 0, 3'b100);
        add(1, 8'h44, 8'h64, 1, 8'h40, 0, 0, 3'b010);
        for (int i = 0; i < 5; i++) add(1, 8'(8'h44 + i), 8'(8'h64 + i), 0, 0, 0, 0, 3'b100);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);
        // Writes with no read pending do not count toward the burst.
        for (int i = 0; i < 3; i++) add(1, 8'(8'h50 + i), 8'(8'h70 + i), 0, 0, 0, 0, 3'b100);
        for (int i = 3; i < 7; i++) add(1, 8'(8'h50 + i), 8'(8'h70 + i), 0, 0, 1, 8'h52, 3'b100);
        add(1, 8'h57, 8'h77, 0, 0, 1, 8'h52, 3'b001);
        add(1, 8'h57, 8'h77, 0, 0, 0, 0, 3'b100);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000);

        idle_in();
        wr_req3 = 1'b0; wr_addr3 = '0; wr_data3 = '0;
        rd1_req3 = 1'b0; rd1_addr3 = '0; rd2_req3 = 1'b0; rd2_addr3 = '0;

        // Reset with requests present: they must be ignored.
        reset = 1'b1;
        wr_req = 1'b1; rd1_req = 1'b1; rd2_req = 1'b1;
        rd1_req3 = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_quiet("reset");
        chki("reset3_gnt", int'({wr_gnt3, rd1_gnt3, rd2_gnt3}), 0);
        chk1("reset3_ce", sram_ce3, 1'b0);
        chk1("reset3_v1", rd1_valid3, 1'b0);
        chkw("reset3_d1", rd1_data3, '0);
        next_cycle();
        reset = 1'b0;
        idle_in();
        rd1_req3 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            wr_req = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = {30{vecs[i].wb}};
            rd1_req = vecs[i].r1; rd1_addr = vecs[i].a1;
            rd2_req = vecs[i].r2; rd2_addr = vecs[i].a2;
            @(negedge clock);
            chk_gnt($sformatf("gnt_row%0d", i), vecs[i].exp);
            if (vecs[i].c1) begin
                chk1($sformatf("v1_row%0d", i), rd1_valid, 1'b1);
                chkw($sformatf("d1_row%0d", i), rd1_data, vecs[i].e1);
            end
            if (vecs[i].c2) begin
                chk1($sformatf("v2_row%0d", i), rd2_valid, 1'b1);
                chkw($sformatf("d2_row%0d", i), rd2_data, vecs[i].e2);
            end
            next_cycle();
        end

        // rd2 then rd1 granted back to back (pointer left at port 2), then reset.
        idle_in();
        rd2_req = 1'b1; rd2_addr = 8'h06;
        @(negedge clock); chk_gnt("rst_seq_a", 3'b001);
        next_cycle();
        idle_in();
        rd1_req = 1'b1; rd1_addr = 8'h05;
        @(negedge clock); chk_gnt("rst_seq_b", 3'b010);
        next_cycle();
        reset = 1'b1;
        wr_req = 1'b1; rd1_req = 1'b1; rd2_req = 1'b1;
        @(negedge clock);
        chk_gnt("rst_seq_c_gnt", 3'b000);
        chk1("rst_seq_c_ce", sram_ce, 1'b0);
        next_cycle();
        @(negedge clock);
        chk_quiet("rst_seq_d");
        next_cycle();
        reset = 1'b0;
        idle_in();
        rd1_req = 1'b1; rd1_addr = 8'h07; rd2_req = 1'b1; rd2_addr = 8'h08;
        @(negedge clock); chk_gnt("post_reset_first", 3'b010);
        next_cycle();
        rd1_req = 1'b0;
        @(negedge clock); chk_gnt("post_reset_second", 3'b001);
        next_cycle();
        idle_in();
        repeat (3) next_cycle();

        // Latency-3 instance, top line address.
        rd1_req3 = 1'b1; rd1_addr3 = 8'hFF;
        @(negedge clock);
        chk1("lat3_gnt", rd1_gnt3, 1'b1);
        chk1("lat3_ce", sram_ce3, 1'b1);
        chk1("lat3_we", sram_we3, 1'b0);
        chki("lat3_addr", int'(sram_addr3), 255);
        t0 = cyc;
        next_cycle();
        rd1_req3 = 1'b0;
        pulses = 0;
        arrival = -1;
        got3 = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (rd1_valid3) begin
                pulses++;
                arrival = cyc;
                got3 = rd1_data3;
            end
            chk1("lat3_no_v2", rd2_valid3, 1'b0);
        end
        chki("lat3_pulses", pulses, 1);
        chki("lat3_arrival", arrival, t0 + 4);
        chkw("lat3_data", got3, line_of(8'hFF));
        chkw("lat3_hold", rd1_data3, line_of(8'hFF));

        @(negedge clock);
        chki("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
